// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
// Fetch FSM encoding, NOP word and PC step.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HELD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load, bubble-clear and synchronous reset.
// A bubble zeroes instr/valid but keeps pc4.
import fetch_stage_pkg::*;

module ifid_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [32:0] iv;

    // instr/valid pair and pc4 half; neither load nor bubble means hold
    always_ff @(posedge clk) begin
        if (reset) begin
            iv  <= '0;
            pc4 <= '0;
        end else if (load) begin
            iv  <= {next_instr, 1'b1};
            pc4 <= next_pc4;
        end else if (bubble) begin
            iv  <= {NOP, 1'b0};
        end
    end

    assign instr = iv[32:1];
    assign valid = iv[0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with variable-latency memory and IF/ID register.
// Redirects resolve in decode; a request in flight is drained, not aborted.
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state;
    logic [31:0]  pcf;
    logic [31:0]  pcf_plus4;
    logic [31:0]  target_f;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc4;
    logic         redirect;
    logic [31:0]  target;
    logic         d_load;
    logic         d_bubble;
    logic [31:0]  d_instr;
    logic [31:0]  d_pc4;

    assign pcf_plus4 = pcf + PC_INC;
    assign IMemAddr  = pcf;
    assign IMemReq   = ~Reset & (state != S_HELD);

    // taken branch/jump in decode and its target; jump wins
    always_comb begin
        redirect = ValidD & ~StallD & (PCSrcD | JumpD);
        target   = PCBranchD;
        if (JumpD)
            target = {PCPlus4D[31:28], InstrD[25:0], 2'b00};
    end

    // what the decode register does this cycle
    always_comb begin
        d_load   = 1'b0;
        d_bubble = 1'b0;
        d_instr  = IMemRData;
        d_pc4    = pcf_plus4;
        unique case (state)
            S_REQ: begin
                if (IMemAck && !StallD && !redirect)
                    d_load = 1'b1;
                else if (!StallD)
                    d_bubble = 1'b1;
            end
            S_HELD: begin
                d_instr = hold_instr;
                d_pc4   = hold_pc4;
                if (!StallD && redirect)
                    d_bubble = 1'b1;
                else if (!StallD)
                    d_load = 1'b1;
            end
            S_DROP: begin
                if (!StallD)
                    d_bubble = 1'b1;
            end
            default: begin
                d_bubble = ~StallD;
            end
        endcase
    end

    // fetch FSM: PC, pending redirect target and stall buffer
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= S_REQ;
            pcf        <= RESET_PC;
            target_f   <= '0;
            hold_instr <= '0;
            hold_pc4   <= '0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (IMemAck) begin
                        if (redirect) begin
                            pcf <= target;
                        end else begin
                            pcf <= pcf_plus4;
                            if (StallD) begin
                                hold_instr <= IMemRData;
                                hold_pc4   <= pcf_plus4;
                                state      <= S_HELD;
                            end
                        end
                    end else if (redirect) begin
                        target_f <= target;
                        state    <= S_DROP;
                    end
                end
                S_HELD: begin
                    if (!StallD) begin
                        if (redirect)
                            pcf <= target;
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (IMemAck) begin
                        pcf   <= redirect ? target : target_f;
                        state <= S_REQ;
                    end else if (redirect) begin
                        target_f <= target;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    ifid_reg u_ifid (
        .clk        (CLK),
        .reset      (Reset),
        .load       (d_load),
        .bubble     (d_bubble),
        .next_instr (d_instr),
        .next_pc4   (d_pc4),
        .instr      (InstrD),
        .pc4        (PCPlus4D),
        .valid      (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, hand sequence,
// and random traffic against a queue-based fetch model.
module tb_fetch_stage;

    logic        CLK;
    logic        Reset;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRData;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .StallD    (StallD),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .JumpD     (JumpD),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemAck   (IMemAck),
        .IMemRData (IMemRData),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          pcsrc;
        bit          jump;
        bit          ack;
        logic [31:0] br;
        bit          req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          valid;
    } vec_t;

    vec_t tbl[30];

    // reference model state
    logic [31:0] m_pc;
    logic [63:0] m_buf[$];
    bit          m_kill;
    logic [31:0] m_kill_tgt;
    logic [31:0] d_instr;
    logic [31:0] d_pc4;
    bit          d_valid;

    function automatic logic [31:0] mw(input logic [31:0] a);
        if (a == 32'h1000_0000)
            return 32'h0800_0010;
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t v(
        input bit rst, input bit stall, input bit pcsrc,
        input bit jump, input bit ack, input logic [31:0] br,
        input bit req, input logic [31:0] addr,
        input logic [31:0] instr, input logic [31:0] pc4,
        input bit valid);
        vec_t r;
        r.rst = rst; r.stall = stall; r.pcsrc = pcsrc;
        r.jump = jump; r.ack = ack; r.br = br;
        r.req = req; r.addr = addr; r.instr = instr;
        r.pc4 = pc4; r.valid = valid;
        return r;
    endfunction

    task automatic drive(
        input bit rst, input bit stall, input bit pcsrc,
        input bit jump, input bit ack, input logic [31:0] br,
        input logic [31:0] rdata);
        @(negedge CLK);
        Reset     = rst;
        StallD    = stall;
        PCSrcD    = pcsrc;
        JumpD     = jump;
        IMemAck   = ack;
        PCBranchD = br;
        IMemRData = rdata;
        #1;
    endtask

    task automatic check(
        input string nm, input bit er, input logic [31:0] ea,
        input logic [31:0] ei, input logic [31:0] ep, input bit ev);
        n_vec++;
        if (IMemReq !== er || IMemAddr !== ea || InstrD !== ei ||
            PCPlus4D !== ep || ValidD !== ev) begin
            n_err++;
            $display("FAIL %s: got req=%0b addr=%h instr=%h pc4=%h valid=%0b, want req=%0b addr=%h instr=%h pc4=%h valid=%0b",
                     nm, IMemReq, IMemAddr, InstrD, PCPlus4D, ValidD,
                     er, ea, ei, ep, ev);
        end
    endtask

    // fetch behaviour: one outstanding request, a one-deep stall buffer,
    // and a kill flag for a request whose data must be thrown away
    task automatic model_step(
        input bit rst, input bit stall, input bit pcsrc,
        input bit jump, input bit ack, input logic [31:0] br,
        input logic [31:0] rdata);
        bit          redir;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0; m_buf.delete(); m_kill = 0; m_kill_tgt = 0;
            d_instr = 0; d_pc4 = 0; d_valid = 0;
        end else begin
            redir = d_valid && !stall && (pcsrc || jump);
            tgt = jump ? {d_pc4[31:28], d_instr[25:0], 2'b00} : br;
            if (m_buf.size() != 0) begin
                if (!stall) begin
                    if (redir) begin
                        m_pc = tgt; d_instr = 0; d_valid = 0;
                    end else begin
                        {d_instr, d_pc4} = m_buf[0]; d_valid = 1;
                    end
                    m_buf.delete();
                end
            end else if (ack) begin
                if (m_kill) begin
                    m_pc = redir ? tgt : m_kill_tgt;
                    m_kill = 0;
                    if (!stall) begin d_instr = 0; d_valid = 0; end
                end else if (redir) begin
                    m_pc = tgt; d_instr = 0; d_valid = 0;
                end else if (stall) begin
                    m_buf.push_back({rdata, m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end else begin
                    d_instr = rdata; d_pc4 = m_pc + 32'd4; d_valid = 1;
                    m_pc = m_pc + 32'd4;
                end
            end else begin
                if (redir) begin m_kill = 1; m_kill_tgt = tgt; end
                if (!stall) begin d_instr = 0; d_valid = 0; end
            end
        end
    endtask

    initial begin
        bit          rst, stall, pcsrc, jump, ack;
        logic [31:0] br, rd;

        Reset = 1; StallD = 0; PCSrcD = 0; JumpD = 0;
        IMemAck = 0; PCBranchD = 0; IMemRData = 0;

        //            rst st  bq  j  ack br            req addr          instr              pc4           v
        tbl[0]  = v(1, 0, 0, 0, 1, 32'h0,         0, 32'h0,         32'h0,             32'h0,         0);
        tbl[1]  = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h0,         32'h0,             32'h0,         0);
        tbl[2]  = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h4,         mw(32'h0),         32'h4,         1);
        tbl[3]  = v(0, 0, 0, 0, 0, 32'h0,         1, 32'h8,         mw(32'h4),         32'h8,         1);
        tbl[4]  = v(0, 0, 0, 0, 0, 32'h0,         1, 32'h8,         32'h0,             32'h8,         0);
        tbl[5]  = v(0, 0, 0, 0, 0, 32'h0,         1, 32'h8,         32'h0,             32'h8,         0);
        tbl[6]  = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h8,         32'h0,             32'h8,         0);
        tbl[7]  = v(0, 1, 0, 0, 1, 32'h0,         1, 32'hC,         mw(32'h8),         32'hC,         1);
        tbl[8]  = v(0, 1, 0, 0, 0, 32'h0,         0, 32'h10,        mw(32'h8),         32'hC,         1);
        tbl[9]  = v(0, 0, 0, 0, 0, 32'h0,         0, 32'h10,        mw(32'h8),         32'hC,         1);
        tbl[10] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h10,        mw(32'hC),         32'h10,        1);
        tbl[11] = v(0, 0, 1, 0, 1, 32'h40,        1, 32'h14,        mw(32'h10),        32'h14,        1);
        tbl[12] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h40,        32'h0,             32'h14,        0);
        tbl[13] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h44,        mw(32'h40),        32'h44,        1);
        tbl[14] = v(0, 0, 1, 0, 1, 32'h1000_0000, 1, 32'h48,        mw(32'h44),        32'h48,        1);
        tbl[15] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h1000_0000, 32'h0,             32'h48,        0);
        tbl[16] = v(0, 0, 0, 1, 0, 32'h0,         1, 32'h1000_0004, 32'h0800_0010,     32'h1000_0004, 1);
        tbl[17] = v(0, 0, 0, 0, 0, 32'h0,         1, 32'h1000_0004, 32'h0,             32'h1000_0004, 0);
        tbl[18] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h1000_0004, 32'h0,             32'h1000_0004, 0);
        tbl[19] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h1000_0040, 32'h0,             32'h1000_0004, 0);
        tbl[20] = v(0, 0, 1, 0, 0, 32'h80,        1, 32'h1000_0044, mw(32'h1000_0040), 32'h1000_0044, 1);
        tbl[21] = v(1, 0, 0, 0, 1, 32'h0,         0, 32'h1000_0044, 32'h0,             32'h1000_0044, 0);
        tbl[22] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h0,         32'h0,             32'h0,         0);
        tbl[23] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h4,         mw(32'h0),         32'h4,         1);
        tbl[24] = v(0, 0, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h8,         mw(32'h4),         32'h8,         1);
        tbl[25] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0,             32'h8,         0);
        tbl[26] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h0,         mw(32'hFFFF_FFFC), 32'h0,         1);
        tbl[27] = v(0, 1, 0, 0, 1, 32'h0,         1, 32'h4,         mw(32'h0),         32'h4,         1);
        tbl[28] = v(0, 0, 1, 0, 0, 32'h200,       0, 32'h8,         mw(32'h0),         32'h4,         1);
        tbl[29] = v(0, 0, 0, 0, 1, 32'h0,         1, 32'h200,       32'h0,             32'h4,         0);

        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].pcsrc, tbl[i].jump,
                  tbl[i].ack, tbl[i].br, mw(tbl[i].addr));
            check($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr,
                  tbl[i].instr, tbl[i].pc4, tbl[i].valid);
        end

        // stall buffer filled, ack ignored while held, reset from S_HELD
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h0, mw(32'h0));
        check("held_a", 1, 32'h0, 32'h0, 32'h0, 0);
        drive(0, 1, 0, 0, 1, 32'h0, mw(32'h4));
        check("held_b", 1, 32'h4, mw(32'h0), 32'h4, 1);
        drive(0, 1, 0, 0, 1, 32'h0, 32'hDEAD_BEEF);
        check("held_c", 0, 32'h8, mw(32'h0), 32'h4, 1);
        drive(1, 1, 0, 0, 1, 32'h0, 32'hDEAD_BEEF);
        check("held_rst", 0, 32'h8, mw(32'h0), 32'h4, 1);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("held_post", 1, 32'h0, 32'h0, 32'h0, 0);

        // random traffic against the model
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        model_step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 3) == 0);
            pcsrc = ($urandom_range(0, 5) == 0);
            jump  = ($urandom_range(0, 7) == 0);
            ack   = ($urandom_range(0, 2) != 0);
            br    = $urandom;
            rd    = $urandom;
            drive(rst, stall, pcsrc, jump, ack, br, rd);
            check($sformatf("rand%0d", c), !rst && (m_buf.size() == 0),
                  m_pc, d_instr, d_pc4, d_valid);
            model_step(rst, stall, pcsrc, jump, ack, br, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
